// File: rtl/image_pkg.sv
// Shared definitions for the image adder result path.
//   PIX_W / IMG_ADDR_W / IMG_DEPTH : result RAM geometry
//   state_t                        : streamer FSM states
//   pix_t                          : one pixel sum
package image_pkg;
  localparam int PIX_W      = 8;
  localparam int IMG_ADDR_W = 6;
  localparam int IMG_DEPTH  = 64;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  typedef logic [PIX_W-1:0] pix_t;
endpackage

// File: rtl/stream_skid_fifo.sv
// 2-entry FIFO of {sof, eof, data}. The head entry is a register and drives
// the stream outputs directly, so the consumer sees flop outputs.
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   push, push_sof/eof/data   : write one entry (never while full)
//   pop                       : remove head entry (ignored when empty)
//   head_sof/eof/data         : head entry contents
//   count, full, empty        : occupancy
module stream_skid_fifo #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              push_sof,
  input  logic              push_eof,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              head_sof,
  output logic              head_eof,
  output logic [DATA_W-1:0] head_data,
  output logic [1:0]        count,
  output logic              full,
  output logic              empty
);
  logic              q1_sof, q1_eof;
  logic [DATA_W-1:0] q1_data;
  logic              pop_ok;

  assign full   = (count == 2'd2);
  assign empty  = (count == 2'd0);
  assign pop_ok = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= 2'd0;
      head_sof  <= 1'b0;
      head_eof  <= 1'b0;
      head_data <= '0;
      q1_sof    <= 1'b0;
      q1_eof    <= 1'b0;
      q1_data   <= '0;
    end else begin
      case ({push, pop_ok})
        2'b10: begin
          if (empty) begin
            {head_sof, head_eof, head_data} <= {push_sof, push_eof, push_data};
          end else begin
            {q1_sof, q1_eof, q1_data} <= {push_sof, push_eof, push_data};
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          {head_sof, head_eof, head_data} <= {q1_sof, q1_eof, q1_data};
          count <= count - 2'd1;
        end
        2'b11: begin
          // With one entry the new word goes straight to the head;
          // with two the second entry advances and the new word backfills.
          if (count == 2'd1) begin
            {head_sof, head_eof, head_data} <= {push_sof, push_eof, push_data};
          end else begin
            {head_sof, head_eof, head_data} <= {q1_sof, q1_eof, q1_data};
            {q1_sof, q1_eof, q1_data}       <= {push_sof, push_eof, push_data};
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/image_sum_streamer.sv
// Streams one frame of the result RAM (2**ADDR_W pixels) as valid/ready
// beats with sof/eof markers, absorbing the 1-cycle RAM latency and
// consumer backpressure with a 2-entry skid FIFO.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, busy, done   : frame control (start ignored while busy)
//   ram_en, ram_addr    : read request to result RAM
//   ram_dout            : RAM data, valid 1 cycle after ram_en
//   m_valid, m_ready    : output handshake
//   m_data, m_sof, m_eof: output beat
//   checksum            : only with IMAGE_SUM_STREAMER_CHECKSUM_EN defined;
//                         sum of streamed pixels, cleared on accepted start
module image_sum_streamer
  import image_pkg::*;
#(
  parameter int ADDR_W = IMG_ADDR_W,
  parameter int DATA_W = PIX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sof,
  output logic              m_eof,
  output logic              done
`ifdef IMAGE_SUM_STREAMER_CHECKSUM_EN
  ,
  output logic [DATA_W+ADDR_W-1:0] checksum
`endif
);
  localparam logic [ADDR_W-1:0] LAST = '1;

  state_t            state, state_n;
  logic [ADDR_W-1:0] cnt;
  logic              inflight;
  logic [ADDR_W-1:0] infl_addr;
  logic [1:0]        fifo_count;
  logic [1:0]        occ;
  logic              fifo_full, fifo_empty;
  logic              head_sof, head_eof;
  logic              pop, issue_ok;

  assign pop      = m_valid && m_ready;
  // Slots committed = stored entries + the read still in flight. A pop this
  // cycle frees a slot in time for the data that lands two cycles later.
  assign occ      = fifo_count + {1'b0, inflight};
  assign issue_ok = (occ < 2'd2) || ((occ == 2'd2) && pop);

  assign busy     = (state != IDLE);
  assign ram_addr = cnt;
  assign m_valid  = !fifo_empty;
  assign m_sof    = head_sof && !fifo_empty;
  assign m_eof    = head_eof && !fifo_empty;

  always_comb begin
    state_n = state;
    ram_en  = 1'b0;
    done    = 1'b0;
    case (state)
      IDLE:  if (start) state_n = READ;
      READ: begin
        if (issue_ok) begin
          ram_en = 1'b1;
          if (cnt == LAST) state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (!inflight && fifo_empty) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      inflight  <= 1'b0;
      infl_addr <= '0;
    end else begin
      state    <= state_n;
      inflight <= ram_en;
      if (ram_en) begin
        infl_addr <= cnt;
        cnt       <= cnt + 1'b1;
      end
      if (state == IDLE && start) cnt <= '0;
    end
  end

  stream_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_sof  (infl_addr == '0),
    .push_eof  (infl_addr == LAST),
    .push_data (ram_dout),
    .pop       (pop),
    .head_sof  (head_sof),
    .head_eof  (head_eof),
    .head_data (m_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef IMAGE_SUM_STREAMER_CHECKSUM_EN
  // Width covers 2**ADDR_W full-scale pixels, so it cannot overflow.
  always_ff @(posedge clk) begin
    if (rst)                        checksum <= '0;
    else if (state == IDLE && start) checksum <= '0;
    else if (pop)                   checksum <= checksum + {{ADDR_W{1'b0}}, m_data};
  end
`endif
endmodule

// File: tb/tb_image_sum_streamer.sv
module tb_image_sum_streamer;
  import image_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, m_ready;
  logic        busy, ram_en, m_valid, m_sof, m_eof, done;
  logic [5:0]  ram_addr;
  logic [7:0]  ram_dout, m_data;
`ifdef IMAGE_SUM_STREAMER_CHECKSUM_EN
  logic [13:0] checksum;
`endif

  image_sum_streamer dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_dout(ram_dout),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eof(m_eof), .done(done)
`ifdef IMAGE_SUM_STREAMER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  pix_t mem [0:IMG_DEPTH-1];
  pix_t expv[0:IMG_DEPTH-1];
  always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Beat recorder and protocol monitors, sampled mid-cycle.
  int   nb, ndone, nren, first_en, done_cyc;
  int   occ_viol = 0, push_full_viol = 0, stab_viol = 0;
  logic [7:0] bdata [0:127];
  logic       bsof  [0:127];
  logic       beof  [0:127];
  int         bcyc  [0:127];
  logic       stall_prev = 1'b0;
  logic [7:0] pd;
  logic       ps, pe;

  always @(negedge clk) begin
    if (m_valid && m_ready && nb < 128) begin
      bdata[nb] = m_data; bsof[nb] = m_sof; beof[nb] = m_eof; bcyc[nb] = cyc;
      nb++;
    end
    if (done) begin ndone++; done_cyc = cyc; end
    if (ram_en) begin if (nren == 0) first_en = cyc; nren++; end
    if (ram_en && (int'(dut.fifo_count) + int'(dut.inflight)) == 2 && !(m_valid && m_ready))
      occ_viol++;
    if (dut.u_fifo.push && dut.u_fifo.full) push_full_viol++;
    if (!rst && stall_prev && (!m_valid || m_data !== pd || m_sof !== ps || m_eof !== pe))
      stab_viol++;
    stall_prev = m_valid && !m_ready;
    pd = m_data; ps = m_sof; pe = m_eof;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_mon();
    nb = 0; ndone = 0; nren = 0; first_en = -1; done_cyc = -1;
  endtask

  task automatic pulse_start(output int t);
    t = cyc; start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (ndone < 1 && k < bound) begin tick(); k++; end
    chk("done_seen", 32'(ndone >= 1), 1);
  endtask

  task automatic check_frame(input string tag);
    int bad = 0, nsof = 0, neof = 0;
    chk({tag, "_beats"}, nb, 64);
    for (int i = 0; i < nb && i < 64; i++) begin
      if (bdata[i] !== expv[i]) bad++;
      if (bsof[i]) nsof++;
      if (beof[i]) neof++;
    end
    chk({tag, "_data_bad"}, bad, 0);
    chk({tag, "_sof_first"}, 32'(bsof[0]), 1);
    chk({tag, "_eof_last"}, 32'(beof[63]), 1);
    chk({tag, "_sof_cnt"}, nsof, 1);
    chk({tag, "_eof_cnt"}, neof, 1);
  endtask

  task automatic fill(input int mode);
    for (int i = 0; i < IMG_DEPTH; i++) begin
      case (mode)
        0:       mem[i] = pix_t'((i * 3) % 256);
        1:       mem[i] = 8'hFF;
        default: mem[i] = 8'h01;
      endcase
      expv[i] = mem[i];
    end
  endtask

  int t;

  initial begin
    rst = 1'b1; start = 1'b0; m_ready = 1'b0;
    clr_mon();
    fill(0);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ram_en", 32'(ram_en), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_data", 32'(m_data), 0);
    chk("rst_sof_eof_done", {29'd0, m_sof, m_eof, done}, 0);

    // Frame 1: m_ready held high, latency and ordering.
    m_ready = 1'b1; clr_mon();
    pulse_start(t);
    chk("busy_after_start", 32'(busy), 1);
    wait_done(300);
    check_frame("f1");
    chk("f1_bytes_2_5", {bdata[2], bdata[5], 16'd0}, {8'd6, 8'd15, 16'd0});
    chk("f1_last_data", 32'(bdata[63]), 189);
    chk("f1_first_en", first_en, t + 1);
    chk("f1_first_valid", bcyc[0], t + 3);
    chk("f1_last_beat", bcyc[63], t + 66);
    chk("f1_done_cyc", done_cyc, t + 67);
    chk("f1_nren", nren, 64);
    tick();
    chk("f1_busy_low", 32'(busy), 0);
    tick();

    // Frame 2: toggling then stalled consumer mid-frame.
    clr_mon();
    pulse_start(t);
    begin
      int k = 0;
      while (ndone < 1 && k < 400) begin
        if (k >= 12 && k < 16)      m_ready = ((k - 12) % 2 == 0);
        else if (k >= 16 && k < 26) m_ready = 1'b0;
        else                        m_ready = 1'b1;
        tick(); k++;
      end
    end
    chk("f2_done_seen", 32'(ndone), 1);
    check_frame("f2");
    chk("f2_stable", stab_viol, 0);
    chk("f2_occ_issue", occ_viol, 0);
    chk("f2_push_full", push_full_viol, 0);
    m_ready = 1'b1;
    repeat (2) tick();

    // Frame 3: start pulsed again at beat 20 is ignored.
    clr_mon();
    pulse_start(t);
    begin
      int k = 0;
      while (nb < 20 && k < 200) begin tick(); k++; end
    end
    start = 1'b1; tick(); start = 1'b0;
    wait_done(300);
    repeat (10) tick();
    check_frame("f3");
    chk("f3_one_done", ndone, 1);

    // Frame 4: reset at beat 30, then a fresh frame.
    clr_mon();
    pulse_start(t);
    begin
      int k = 0;
      while (nb < 30 && k < 200) begin tick(); k++; end
    end
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ram_en_addr", {ram_en, 26'd0, ram_addr}, 0);
    chk("abort_stream", {m_valid, m_sof, m_eof, done, 20'd0, m_data}, 0);
    repeat (10) tick();
    chk("abort_no_done", ndone, 0);
    clr_mon();
    pulse_start(t);
    wait_done(300);
    check_frame("f4");
    repeat (2) tick();

    // Boundary: consumer not ready from the start cycle.
    clr_mon();
    m_ready = 1'b0;
    pulse_start(t);
    repeat (19) tick();
    chk("bp_nren", nren, 2);
    chk("bp_valid", 32'(m_valid), 1);
    chk("bp_data", 32'(m_data), 0);
    chk("bp_sof", 32'(m_sof), 1);
    m_ready = 1'b1;
    wait_done(300);
    check_frame("bp");
    chk("bp_occ_issue", occ_viol, 0);
    chk("bp_push_full", push_full_viol, 0);
    chk("bp_stable", stab_viol, 0);
    repeat (2) tick();

`ifdef IMAGE_SUM_STREAMER_CHECKSUM_EN
    fill(1); clr_mon();
    pulse_start(t);
    wait_done(300);
    chk("cks_ff", 32'(checksum), 16320);
    fill(2);
    tick();
    clr_mon();
    pulse_start(t);
    wait_done(300);
    chk("cks_01", 32'(checksum), 64);
    check_frame("cks");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
